// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: sequencer states, width defaults,
// reset vector, next-PC select codes and the decoder's control opcodes.
package core_pkg;

    localparam int PC_WIDTH_DEF    = 10;
    localparam int INSTR_WIDTH_DEF = 8;
    localparam int RESET_PC_DEF    = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_FWD  = 2'd2,
        PC_BWD  = 2'd3
    } pc_sel_e;

    localparam logic [7:0] OP_HALT    = 8'hFF;
    localparam logic [7:0] OP_BRANCHF = 8'h40;
    localparam logic [7:0] OP_BRANCHB = 8'h50;
    localparam logic [7:0] OP_LOAD    = 8'h80;
    localparam logic [7:0] OP_STORE   = 8'h90;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC select: hold, +1, +offset or -offset, all modulo
// 2^PC_WIDTH with the 8-bit branch offset zero-extended.
module pc_next_unit
    import core_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [7:0]          offset_i,
    input  pc_sel_e             sel_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] offset_ext_s;

    assign offset_ext_s = {{(PC_WIDTH-8){1'b0}}, offset_i};

    // Wrap-around comes for free from the fixed-width adders.
    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            PC_HOLD: pc_next_o = pc_i;
            PC_INC:  pc_next_o = pc_i + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            PC_FWD:  pc_next_o = pc_i + offset_ext_s;
            PC_BWD:  pc_next_o = pc_i - offset_ext_s;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns the PC, fetches over a req/ack port, hands each
// instruction to the decoder and steps the PC from the decoded control flow.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int                   PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                   INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_WIDTH-1:0] imem_data_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    input  logic                   branchf_i,
    input  logic                   branchb_i,
    input  logic                   halt_i,
    input  logic [7:0]             offset_i,
    input  logic                   dmem_busy_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic                   halted_o,
    output logic [15:0]            retired_o,
    output logic                   branch_err_o
);

    state_e                 state_q,   state_d;
    logic [PC_WIDTH-1:0]    pc_q,      pc_d;
    logic                   req_q,     req_d;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
    logic                   valid_q,   valid_d;
    logic                   halted_q,  halted_d;
    logic [15:0]            retired_q, retired_d;
    logic                   err_q,     err_d;

    pc_sel_e                pc_sel_s;
    logic [PC_WIDTH-1:0]    pc_next_s;

    // Branch direction chosen in EXEC; forward wins if the decoder flags both.
    always_comb begin
        pc_sel_s = PC_HOLD;
        if (state_q == ST_EXEC && !dmem_busy_i && !halt_i) begin
            if (branchf_i) begin
                pc_sel_s = PC_FWD;
            end else if (branchb_i) begin
                pc_sel_s = PC_BWD;
            end else begin
                pc_sel_s = PC_INC;
            end
        end else begin
            pc_sel_s = PC_HOLD;
        end
    end

    pc_next_unit #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc_i      (pc_q),
        .offset_i  (offset_i),
        .sel_i     (pc_sel_s),
        .pc_next_o (pc_next_s)
    );

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        halted_d  = halted_q;
        retired_d = retired_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    req_d     = 1'b1;
                    retired_d = 16'd0;
                    err_d     = 1'b0;
                end else begin
                    req_d     = 1'b0;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    state_d = ST_DECODE;
                    instr_d = imem_data_i;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    req_d   = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
                req_d   = 1'b0;
            end
            ST_EXEC: begin
                if (branchf_i && branchb_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (dmem_busy_i) begin
                    state_d = ST_EXEC;
                end else if (halt_i) begin
                    state_d   = ST_HALTED;
                    halted_d  = 1'b1;
                    retired_d = sat_inc16(retired_q);
                end else begin
                    state_d   = ST_FETCH;
                    pc_d      = pc_next_s;
                    req_d     = 1'b1;
                    retired_d = sat_inc16(retired_q);
                end
            end
            ST_HALTED: begin
                // Restart from HALTED behaves exactly like the first start.
                if (start_i) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    req_d     = 1'b1;
                    halted_d  = 1'b0;
                    retired_d = 16'd0;
                    err_d     = 1'b0;
                end else begin
                    req_d     = 1'b0;
                    halted_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding fetch.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign retired_o     = retired_q;
    assign branch_err_o  = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: straight-line fetch, branches with wrap,
// slow ack, dmem stall, halt/restart and reset mid-fetch.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_data;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        bf;
    logic        bb;
    logic        halt;
    logic [7:0]  offset;
    logic        busy;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] retired;
    logic        berr;

    int tests_run;
    int tests_failed;
    int valid_cnt;

    fetch_sequencer dut (
        .clock_i       (clk),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .branchf_i     (bf),
        .branchb_i     (bb),
        .halt_i        (halt),
        .offset_i      (offset),
        .dmem_busy_i   (busy),
        .pc_o          (pc),
        .halted_o      (halted),
        .retired_o     (retired),
        .branch_err_o  (berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: instruction word is a fixed pattern of its address.
    assign imem_data = 8'hA0 ^ imem_addr[7:0];

    always @(negedge clk) begin
        if (instr_valid) valid_cnt = valid_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH with zero-wait ack.
    task automatic do_instr(input logic f, input logic b, input logic h, input logic [7:0] off);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        bf = f; bb = b; halt = h; offset = off;
        tick();
        bf = 1'b0; bb = 1'b0; halt = 1'b0; offset = 8'd0;
    endtask

    initial begin
        logic [7:0] exp_instr;
        tests_run = 0; tests_failed = 0; valid_cnt = 0;
        reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0;
        bf = 1'b0; bb = 1'b0; halt = 1'b0; offset = 8'd0; busy = 1'b0;
        tick(); tick();
        check_eq("rst_pc", 32'(pc), 32'h0);
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_instr", 32'(instr), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_retired", 32'(retired), 32'h0);
        check_eq("rst_berr", 32'(berr), 32'h0);

        // Straight-line: ack tied high, 3 cycles per instruction.
        reset_n = 1'b1;
        tick();
        check_eq("idle_req", 32'(imem_req), 32'h0);
        valid_cnt = 0;
        imem_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_instr = 8'hA0 ^ 8'(i);
            check_eq("seq_req", 32'(imem_req), 32'h1);
            check_eq("seq_addr", 32'(imem_addr), 32'(i));
            tick();
            check_eq("seq_valid", 32'(instr_valid), 32'h1);
            check_eq("seq_instr", 32'(instr), 32'(exp_instr));
            check_eq("seq_req_drop", 32'(imem_req), 32'h0);
            tick();
            check_eq("seq_valid_low", 32'(instr_valid), 32'h0);
            tick();
        end
        imem_ack = 1'b0;
        check_eq("seq_addr4", 32'(imem_addr), 32'h4);
        check_eq("seq_retired", 32'(retired), 32'd4);
        check_eq("seq_valid_cnt", 32'(valid_cnt), 32'd4);

        // Branches and PC wrap.
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("br_pc5", 32'(imem_addr), 32'h5);
        do_instr(1'b1, 1'b0, 1'b0, 8'd3);
        check_eq("br_fwd", 32'(imem_addr), 32'h8);
        do_instr(1'b0, 1'b1, 1'b0, 8'd10);
        check_eq("br_bwd_wrap", 32'(imem_addr), 32'h3FE);
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("inc_3ff", 32'(imem_addr), 32'h3FF);
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("inc_wrap", 32'(imem_addr), 32'h0);
        check_eq("br_berr_clear", 32'(berr), 32'h0);

        // Slow ack: request and address held for 4 wait cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wait_req", 32'(imem_req), 32'h1);
            check_eq("wait_addr", 32'(imem_addr), 32'h0);
            check_eq("wait_valid", 32'(instr_valid), 32'h0);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_eq("ack_decode", 32'(instr_valid), 32'h1);
        check_eq("ack_req_drop", 32'(imem_req), 32'h0);
        tick();
        tick();
        check_eq("ack_next_addr", 32'(imem_addr), 32'h1);
        check_eq("ack_retired", 32'(retired), 32'd10);

        // dmem stall of 3 cycles at pc 2, spurious ack during EXEC.
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("ld_pc2", 32'(imem_addr), 32'h2);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        busy = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_req", 32'(imem_req), 32'h0);
            check_eq("stall_valid", 32'(instr_valid), 32'h0);
            check_eq("stall_pc", 32'(pc), 32'h2);
            check_eq("stall_retired", 32'(retired), 32'd11);
        end
        busy = 1'b0;
        imem_ack = 1'b0;
        tick();
        check_eq("stall_next", 32'(imem_addr), 32'h3);
        check_eq("stall_req_up", 32'(imem_req), 32'h1);
        check_eq("stall_retired1", 32'(retired), 32'd12);

        // Halt at pc 6 beats a simultaneous forward branch.
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("halt_at6", 32'(imem_addr), 32'h6);
        do_instr(1'b1, 1'b0, 1'b1, 8'd5);
        check_eq("halt_flag", 32'(halted), 32'h1);
        check_eq("halt_pc", 32'(pc), 32'h6);
        check_eq("halt_req", 32'(imem_req), 32'h0);
        check_eq("halt_retired", 32'(retired), 32'd16);
        imem_ack = 1'b1;
        tick(); tick();
        imem_ack = 1'b0;
        check_eq("halt_hold_pc", 32'(pc), 32'h6);
        check_eq("halt_hold_req", 32'(imem_req), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_addr", 32'(imem_addr), 32'h0);
        check_eq("restart_req", 32'(imem_req), 32'h1);
        check_eq("restart_retired", 32'(retired), 32'h0);
        check_eq("restart_halted", 32'(halted), 32'h0);

        // Both branches: forward wins, error sticks; reset mid-FETCH clears it.
        do_instr(1'b1, 1'b1, 1'b0, 8'd4);
        check_eq("both_fwd", 32'(imem_addr), 32'h4);
        check_eq("both_berr", 32'(berr), 32'h1);
        do_instr(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("berr_sticky", 32'(berr), 32'h1);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        imem_ack = 1'b1;
        check_eq("mid_rst_req", 32'(imem_req), 32'h0);
        check_eq("mid_rst_pc", 32'(pc), 32'h0);
        check_eq("mid_rst_berr", 32'(berr), 32'h0);
        check_eq("mid_rst_retired", 32'(retired), 32'h0);
        tick();
        imem_ack = 1'b0;
        check_eq("late_ack_valid", 32'(instr_valid), 32'h0);
        check_eq("late_ack_req", 32'(imem_req), 32'h0);
        check_eq("late_ack_instr", 32'(instr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
